// File: rtl/minterm_lut_engine_if.sv
`default_nettype none
// ============================================================================
// Interface : minterm_lut_engine_if
// Brief     : Input stream, result stream, serial table-load port and hit
//             counter of the minterm LUT engine, bundled for one connection.
// Revision  : 1.0 - initial release
// ============================================================================
interface minterm_lut_engine_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned CNT_W = 8
);
   // input vector stream
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_a;

   // registered result stream
   logic             out_valid;
   logic             out_ready;
   logic             out_q;
   logic [N-1:0]     out_a;

   // serial truth-table load port
   logic             cfg_start;
   logic             cfg_bit_valid;
   logic             cfg_bit;
   logic             cfg_abort;
   logic             cfg_busy;

   // count of delivered results equal to 1
   logic [CNT_W-1:0] hit_cnt;

   // Producer/consumer side (testbench or surrounding logic)
   modport master (
      output in_valid, in_a, out_ready,
      output cfg_start, cfg_bit_valid, cfg_bit, cfg_abort,
      input  in_ready, out_valid, out_q, out_a, cfg_busy, hit_cnt
   );

   // Engine side
   modport slave (
      input  in_valid, in_a, out_ready,
      input  cfg_start, cfg_bit_valid, cfg_bit, cfg_abort,
      output in_ready, out_valid, out_q, out_a, cfg_busy, hit_cnt
   );
endinterface
`default_nettype wire

// File: rtl/minterm_lut_engine.sv
`default_nettype none
// ============================================================================
// Module   : minterm_lut_engine
// Brief    : Evaluates an N-input boolean function stored as a 2^N-bit truth
//            table. Vectors arrive on a valid/ready stream and results leave
//            on a registered valid/ready stream. The table can be replaced
//            at run time through a serial, MSB-first load port that commits
//            atomically, and a saturating counter tallies results equal to 1.
// Revision : 1.0 - initial release
// ============================================================================
module minterm_lut_engine #(
   parameter int unsigned       N        = 4,
   parameter logic [(2**N)-1:0] RESET_TT = 16'h030B,
   parameter int unsigned       CNT_W    = 8
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   minterm_lut_engine_if.slave bus
);

   localparam int unsigned      c_TT_W     = 2**N;
   localparam logic [N-1:0]     c_LAST_IDX = '1;
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } state_t;

   // control state
   state_t            state_q,   state_d;
   logic [c_TT_W-1:0] tt_q,      tt_d;
   logic [c_TT_W-1:0] shadow_q,  shadow_d;
   logic [N-1:0]      bit_cnt_q, bit_cnt_d;

   // result register and hit counter
   logic              res_valid_q, res_valid_d;
   logic              res_q,       res_d;
   logic [N-1:0]      res_a_q,     res_a_d;
   logic [CNT_W-1:0]  hit_cnt_q,   hit_cnt_d;

   // combinational handshake terms
   logic              w_in_ready;
   logic              w_cfg_busy;
   logic              w_accept;
   logic              w_xfer;

   // Table-load FSM: RUN accepts vectors, LOAD shifts bits into a shadow and
   // swaps the whole table in on the last bit so tt is never partial.
   always_comb begin
      state_d    = state_q;
      tt_d       = tt_q;
      shadow_d   = shadow_q;
      bit_cnt_d  = bit_cnt_q;
      w_in_ready = 1'b0;
      w_cfg_busy = 1'b0;

      case (state_q)
         ST_RUN: begin
            // A slot is free when nothing is held or the held result leaves now
            w_in_ready = !res_valid_q || bus.out_ready;
            if (bus.cfg_start) begin
               state_d   = ST_LOAD;
               shadow_d  = '0;
               bit_cnt_d = '0;
            end
         end

         ST_LOAD: begin
            w_cfg_busy = 1'b1;
            // Abort wins over a bit presented in the same cycle
            if (bus.cfg_abort) begin
               state_d = ST_RUN;
            end else if (bus.cfg_bit_valid) begin
               shadow_d  = {shadow_q[c_TT_W-2:0], bus.cfg_bit};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == c_LAST_IDX) begin
                  tt_d    = {shadow_q[c_TT_W-2:0], bus.cfg_bit};
                  state_d = ST_RUN;
               end
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign w_accept = bus.in_valid && w_in_ready;
   assign w_xfer   = res_valid_q && bus.out_ready;

   // Result register: capture on accept (using the table in force this
   // cycle), clear on a transfer with no replacement, otherwise hold.
   always_comb begin
      res_valid_d = res_valid_q;
      res_d       = res_q;
      res_a_d     = res_a_q;
      hit_cnt_d   = hit_cnt_q;

      if (w_accept) begin
         res_valid_d = 1'b1;
         res_d       = tt_q[bus.in_a];
         res_a_d     = bus.in_a;
      end else if (w_xfer) begin
         res_valid_d = 1'b0;
      end

      // Count delivered ones, sticking at the top value
      if (w_xfer && res_q && (hit_cnt_q != c_CNT_MAX)) begin
         hit_cnt_d = hit_cnt_q + 1'b1;
      end
   end

   // State and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         tt_q        <= RESET_TT;
         shadow_q    <= '0;
         bit_cnt_q   <= '0;
         res_valid_q <= 1'b0;
         res_q       <= 1'b0;
         res_a_q     <= '0;
         hit_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         tt_q        <= tt_d;
         shadow_q    <= shadow_d;
         bit_cnt_q   <= bit_cnt_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
         res_a_q     <= res_a_d;
         hit_cnt_q   <= hit_cnt_d;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = res_valid_q;
   assign bus.out_q     = res_q;
   assign bus.out_a     = res_a_q;
   assign bus.cfg_busy  = w_cfg_busy;
   assign bus.hit_cnt   = hit_cnt_q;

endmodule
`default_nettype wire

// File: doc/minterm_lut_engine.md
Name: minterm_lut_engine

Overview:
- Sequential, parametrised successor to the fixed 4-input sum-of-minterms function.
- Evaluates an N-input boolean function held in a truth-table register. The table resets to sum(0,1,3,8,9) and can be reprogrammed at run time through a serial load port.
- Inputs arrive on a valid/ready stream; results leave on a registered valid/ready stream.
- A saturating counter tallies the results that evaluated to 1.

Parameters:
- N, 4, number of function inputs; the truth table holds 2^N bits.
- RESET_TT, 16'h030B, truth table after reset; bit k is the output for input k. Width is 2^N bits; the default encodes minterms 0,1,3,8,9.
- CNT_W, 8, width of the hit counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_a holds a valid input vector.
- in_ready  out  1  block can accept an input this cycle.
- in_a  in  N  input vector (minterm index).
- out_valid  out  1  out_q holds a result.
- out_ready  in  1  downstream accepts the result.
- out_q  out  1  function value for the accepted vector.
- out_a  out  N  echo of the vector that produced out_q.
- cfg_start  in  1  pulse; begins a serial table load.
- cfg_bit_valid  in  1  cfg_bit holds a valid bit.
- cfg_bit  in  1  table bit, sent MSB (index 2^N-1) first.
- cfg_abort  in  1  abandons a load in progress.
- cfg_busy  out  1  high while in the LOAD state.
- hit_cnt  out  CNT_W  count of results delivered with out_q=1.

Behaviour:
- Reset (async, rst_n=0), all values hold while rst_n is low:
  - state=RUN, tt=RESET_TT, shadow=0, bit_cnt=0.
  - out_valid=0, out_q=0, out_a=0, hit_cnt=0, cfg_busy=0.
- State RUN:
  - in_ready = !out_valid | out_ready.
  - Input accepted when in_valid & in_ready.
  - On accept, next edge sets out_q=tt[in_a], out_a=in_a, out_valid=1. Latency is 1 cycle, throughput 1 per cycle.
  - No accept while out_valid & out_ready: out_valid clears next edge.
  - When out_valid & !out_ready, out_q and out_a hold stable.
- Entering LOAD:
  - cfg_start in RUN moves to LOAD at the next edge, clearing bit_cnt and shadow.
  - An input accepted in the same cycle uses the old tt.
- State LOAD:
  - in_ready=0 and cfg_busy=1.
  - The output register still drains normally (out_ready clears out_valid).
  - Each cycle with cfg_bit_valid, shadow shifts left with cfg_bit entering the LSB, and bit_cnt increments.
- Commit:
  - On the cycle the 2^N-th bit is taken, tt is loaded from {shadow[2^N-2:0],cfg_bit} at that edge.
  - State returns to RUN the same edge; in_ready may be 1 on the following cycle.
  - The table update is atomic; tt never holds a partial value.
- Abort and ignored signals:
  - cfg_abort in LOAD returns to RUN next edge, leaving tt unchanged. Abort has priority over a bit arriving in the same cycle.
  - cfg_start while in LOAD is ignored; loading continues.
  - cfg_bit_valid and cfg_abort in RUN are ignored.
- hit_cnt:
  - Increments when out_valid & out_ready & out_q.
  - Saturates at 2^CNT_W-1, no wrap.
  - Cleared only by reset.
- Asserting rst_n mid-load discards the shadow and restores RESET_TT.

Test Plan:
- Reset defaults: inputs 0,1,2,3,8 streamed with out_ready=1 → out_q 1,1,0,1,1 one cycle after each accept; hit_cnt=4.
- Backpressure: accept a=9, hold out_ready=0 for 3 cycles → out_q=1 and out_a=9 stable, in_ready=0. Release → one transfer, hit_cnt+1.
- Serial load of 16'h8001, then inputs 0,15,3 → out_q 1,1,0. cfg_busy is high exactly until the edge taking bit 16.
- Abort after 7 bits, then input 3 → out_q=1 (old table intact), state RUN.
- Simultaneous events: cfg_start with in_valid a=2 in the same cycle → a=2 evaluated with old table (0), then in_ready=0 during load.
- Saturation with CNT_W=2: 5 consecutive hits → hit_cnt=3. Async rst_n pulse mid-load → hit_cnt=0, tt=RESET_TT.
